// File: rtl/bp_pkg.sv
// bp_pkg: shared encodings for the BTB/RAS branch predictor
package bp_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {BT_BR, BT_JAL, BT_JALR, BT_RET} br_type_e;

    localparam logic [1:0] MP_OK        = 2'b00;
    localparam logic [1:0] MP_NOT_TAKEN = 2'b01;
    localparam logic [1:0] MP_TAKEN     = 2'b10;

    // x1/x5 are the RISC-V link registers used for call/return hints
    function automatic logic is_link(input logic [4:0] r);
        return r == 5'd1 || r == 5'd5;
    endfunction

endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return address stack; overflow overwrites the oldest entry
module bp_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    logic [XLEN-1:0] stack_q [RAS_DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d, top_ptr, wr_ptr;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_pop;

    assign empty_o = cnt_q == '0;
    assign top_ptr = ptr_q - 1'b1;
    assign top_o   = stack_q[top_ptr];
    assign do_pop  = pop_i && !empty_o;

    // push+pop replaces the top in place; a pop on an empty stack is ignored
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_ptr = (push_i && do_pop) ? top_ptr : ptr_q;
        if (push_i && !do_pop) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
        end else if (do_pop && !push_i) begin
            ptr_d = top_ptr;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // pointer and occupancy; reset and flush both empty the stack
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // entry storage, no reset needed since occupancy guards reads
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i && !flush_i)
            stack_q[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/branch_predictor_btb_ras.sv
// branch_predictor_btb_ras: direct-mapped BTB with saturating counters plus return stack
module branch_predictor_btb_ras
    import bp_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 32,
    parameter int CNT_BITS    = 2,
    parameter int CNT_INIT    = 2,
    parameter int RAS_DEPTH   = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            hit_o,
    output logic [XLEN-1:0] predicted_pc_o,
    input  logic            ex_valid_i,
    input  logic [31:0]     inst_ex_i,
    input  logic [XLEN-1:0] pc_ex_i,
    input  logic            br_eq_i,
    input  logic            br_lt_i,
    input  logic [XLEN-1:0] target_ex_i,
    input  logic            hit_ex_i,
    input  logic [XLEN-1:0] pred_pc_ex_i,
    output logic [1:0]      mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(CNT_INIT);

    logic                valid_q [BTB_ENTRIES];
    logic [TAG_W-1:0]    tag_q   [BTB_ENTRIES];
    logic [XLEN-1:0]     tgt_q   [BTB_ENTRIES];
    br_type_e            type_q  [BTB_ENTRIES];
    logic [CNT_BITS-1:0] cnt_q   [BTB_ENTRIES];

    logic [IDX_W-1:0]    f_idx, e_idx;
    logic [TAG_W-1:0]    e_tag;
    logic                f_match, e_match;
    logic [6:0]          opcode;
    logic [2:0]          f3;
    logic [4:0]          rd, rs1;
    logic                is_br, is_jal, is_jalr, br_cond, taken, upd;
    logic                wr_entry, wr_cnt, ras_push, ras_pop, ras_empty;
    br_type_e            ex_type;
    logic [CNT_BITS-1:0] cnt_base, cnt_d;
    logic [XLEN-1:0]     pc_plus4, ras_top;
    logic                unused_bits;

    assign unused_bits = ^{inst_ex_i[31:20], pc_i[1:0], pc_ex_i[1:0]};

    assign f_idx   = pc_i[IDX_W+1:2];
    assign f_match = valid_q[f_idx] && tag_q[f_idx] == pc_i[XLEN-1:IDX_W+2];
    assign hit_o   = f_match && (type_q[f_idx] != BT_BR || cnt_q[f_idx][CNT_BITS-1]);
    assign predicted_pc_o = (type_q[f_idx] == BT_RET && !ras_empty) ? ras_top : tgt_q[f_idx];

    assign opcode  = inst_ex_i[6:0];
    assign rd      = inst_ex_i[11:7];
    assign f3      = inst_ex_i[14:12];
    assign rs1     = inst_ex_i[19:15];
    assign is_br   = opcode == OP_BRANCH;
    assign is_jal  = opcode == OP_JAL;
    assign is_jalr = opcode == OP_JALR;

    assign br_cond = (f3 == F3_BEQ) ? br_eq_i :
                     (f3 == F3_BNE) ? !br_eq_i :
                     (f3 == F3_BLT || f3 == F3_BLTU) ? br_lt_i :
                     (f3 == F3_BGE || f3 == F3_BGEU) ? !br_lt_i : 1'b0;
    assign taken    = is_br ? br_cond : (is_jal || is_jalr);
    assign ex_type  = is_br ? BT_BR : is_jal ? BT_JAL :
                      (is_link(rs1) && !is_link(rd)) ? BT_RET : BT_JALR;
    assign pc_plus4 = pc_ex_i + XLEN'(4);

    assign mispredict_o = !ex_valid_i ? MP_OK :
                          (hit_ex_i && !taken) ? MP_NOT_TAKEN :
                          (taken && (!hit_ex_i || pred_pc_ex_i != target_ex_i)) ? MP_TAKEN : MP_OK;
    assign redirect_pc_o = taken ? target_ex_i : pc_plus4;

    assign e_idx   = pc_ex_i[IDX_W+1:2];
    assign e_tag   = pc_ex_i[XLEN-1:IDX_W+2];
    assign e_match = valid_q[e_idx] && tag_q[e_idx] == e_tag;
    assign upd     = ex_valid_i && !flush_i && !rst_i;

    // fresh allocations start from CNT_INIT before the taken adjustment
    always_comb begin
        cnt_base = e_match ? cnt_q[e_idx] : CNT_RST;
        cnt_d    = taken ? ((cnt_base == '1) ? cnt_base : cnt_base + 1'b1)
                         : ((cnt_base == '0) ? cnt_base : cnt_base - 1'b1);
        wr_entry = upd && taken;
        wr_cnt   = upd && (taken ? (!e_match || is_br) : (e_match && is_br));
    end

    // BTB state: reset clears everything, flush only invalidates, else EX update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                type_q[i]  <= BT_BR;
                cnt_q[i]   <= CNT_RST;
            end
        end else if (flush_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                valid_q[i] <= 1'b0;
        end else begin
            if (wr_entry) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= target_ex_i;
                type_q[e_idx]  <= ex_type;
            end
            if (wr_cnt)
                cnt_q[e_idx] <= cnt_d;
        end
    end

    // link-register hints: rs1==rd with both links means a call only
    assign ras_push = upd && (is_jal || is_jalr) && is_link(rd);
    assign ras_pop  = upd && is_jalr && is_link(rs1) && !(ras_push && rs1 == rd);

    bp_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus4),
        .top_o       (ras_top),
        .empty_o     (ras_empty)
    );

endmodule
